// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the unified memory port.
// master = arbiter side, slave = requesters plus memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              stall;
  logic              protocol_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    input  if_req, if_addr,
    input  d_read, d_write,
    input  d_addr, d_wdata,
    input  mem_rdata, mem_ready,
    output if_rdata, if_valid,
    output d_rdata, d_valid,
    output stall, protocol_err,
    output mem_req, mem_we,
    output mem_addr, mem_wdata
  );

  modport slave (
    output if_req, if_addr,
    output d_read, d_write,
    output d_addr, d_wdata,
    output mem_rdata, mem_ready,
    input  if_rdata, if_valid,
    input  d_rdata, d_valid,
    input  stall, protocol_err,
    input  mem_req, mem_we,
    input  mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for a single-port unified memory.
// Data wins unless fetch has been starved STARVE_MAX grants.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic              clk,
  input logic              arst_n,
  mem_port_arbiter_if.master bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_IF,
    BUSY_D,
    RESP_IF,
    RESP_D
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [SW-1:0]     starve_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              perr_q;

  logic d_pend;
  logic force_if;
  logic grant_d;
  logic grant_if;
  logic mem_done;

  // Grant decision, only meaningful in IDLE
  always_comb begin
    d_pend   = bus.d_read | bus.d_write;
    force_if = (starve_q == SMAX) & bus.if_req;
    grant_d  = (state_q == IDLE) & d_pend & ~force_if;
    grant_if = (state_q == IDLE) & ~grant_d & bus.if_req;
    mem_done = ((state_q == BUSY_IF) |
                (state_q == BUSY_D)) & bus.mem_ready;
  end

  // State register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        unique case (1'b1)
          grant_d:  state_d = BUSY_D;
          grant_if: state_d = BUSY_IF;
          default:  state_d = IDLE;
        endcase
      end
      BUSY_IF: if (bus.mem_ready) state_d = RESP_IF;
      BUSY_D:  if (bus.mem_ready) state_d = RESP_D;
      RESP_IF: state_d = IDLE;
      RESP_D:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state and held registers
  always_comb begin
    bus.mem_req      = (state_q == BUSY_IF) |
                       (state_q == BUSY_D);
    bus.if_valid     = (state_q == RESP_IF);
    bus.d_valid      = (state_q == RESP_D);
    bus.mem_we       = we_q;
    bus.mem_addr     = addr_q;
    bus.mem_wdata    = wdata_q;
    bus.if_rdata     = if_rdata_q;
    bus.d_rdata      = d_rdata_q;
    bus.protocol_err = perr_q;
    bus.stall        = (bus.if_req & ~bus.if_valid) |
                       (d_pend & ~bus.d_valid);
  end

  // Latch the granted request onto the memory bus
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else if (grant_d) begin
      addr_q  <= bus.d_addr;
      wdata_q <= bus.d_write ? bus.d_wdata : '0;
      we_q    <= bus.d_write;
    end else if (grant_if) begin
      addr_q  <= bus.if_addr;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end
  end

  // Capture read data for the owner; stores keep d_rdata
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else if (mem_done) begin
      if (state_q == BUSY_IF)
        if_rdata_q <= bus.mem_rdata;
      else if (!we_q)
        d_rdata_q <= bus.mem_rdata;
    end
  end

  // Count data grants that left fetch waiting
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      starve_q <= '0;
    end else if (grant_d) begin
      if (!bus.if_req)
        starve_q <= '0;
      else if (starve_q != SMAX)
        starve_q <= starve_q + 1'b1;
    end else if (grant_if) begin
      starve_q <= '0;
    end
  end

  // Sticky flag for a simultaneous load/store grant
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)
      perr_q <= 1'b0;
    else if (grant_d & bus.d_read & bus.d_write)
      perr_q <= 1'b1;
  end

endmodule
